// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder:
// funct3 codes, FSM state, captured request, MMIO address.
package dmem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: load select/extend, store
// byte enables + replication, misalign and funct3 checks.
// Ports: we, funct3, lane, wdata, rword in;
//        rdata, be, wdata_rep, misalign, f3_bad out.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misalign,
  output logic        f3_bad
);

  logic [31:0] sh;

  always_comb begin
    sh        = rword >> {lane, 3'b000};
    rdata     = '0;
    be        = '0;
    wdata_rep = wdata;
    unique case (funct3)
      F3_B: begin
        rdata     = {{24{sh[7]}}, sh[7:0]};
        be        = 4'b0001 << lane;
        wdata_rep = {4{wdata[7:0]}};
      end
      F3_H: begin
        rdata     = {{16{sh[15]}}, sh[15:0]};
        be        = 4'b0011 << lane;
        wdata_rep = {2{wdata[15:0]}};
      end
      F3_W: begin
        rdata = rword;
        be    = 4'b1111;
      end
      F3_BU: rdata = {24'b0, sh[7:0]};
      F3_HU: rdata = {16'b0, sh[15:0]};
      default: ;
    endcase
    misalign = (funct3[1:0] == 2'b01 && lane[0])
            || (funct3[1:0] == 2'b10 && lane != 2'b00);
    // Stores only have SB/SH/SW; loads lack 011/110/111.
    f3_bad = we ? (funct3 >= 3'b011)
                : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
  end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data memory with valid/ready request and
// response channels and RV32I load/store widths.
// Ports: clk, reset (async, low), req_* in, req_ready,
// rsp_valid/rsp_rdata/rsp_err out, rsp_ready in.
// DMEM_RESPONDER_MMIO_EN adds led/red/green/blue outputs.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_RESPONDER_MMIO_EN
  ,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
`endif
);

  localparam int IW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] END_ADDR =
    {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  req_t        q;
  req_t        cur;
  logic [31:0] mem [DEPTH_WORDS];

  logic [IW-1:0] idx;
  logic [31:0]   rword;
  logic [31:0]   lane_rd;
  logic [3:0]    be;
  logic [31:0]   wrep;
  logic          misalign;
  logic          f3_bad;
  logic          oor;
  logic          is_mmio;
  logic          mmio_err;
  logic [31:0]   mmio_rd;
  logic          fault;
  logic          enter_resp;

  assign req_ready = (state == ST_IDLE);

  // The request is decoded live on the accept edge (needed
  // when WAIT_CYCLES=0) and from the capture afterwards.
  always_comb begin
    cur = q;
    if (state == ST_IDLE) begin
      cur.we     = req_we;
      cur.funct3 = req_funct3;
      cur.addr   = req_addr;
      cur.wdata  = req_wdata;
    end
  end

  assign idx   = IW'((cur.addr - BASE_ADDR) >> 2);
  assign rword = mem[idx];
  assign oor   = (cur.addr < BASE_ADDR)
              || ({1'b0, cur.addr} >= END_ADDR);

  dmem_lane_align u_align (
    .we        (cur.we),
    .funct3    (cur.funct3),
    .lane      (cur.addr[1:0]),
    .wdata     (cur.wdata),
    .rword     (rword),
    .rdata     (lane_rd),
    .be        (be),
    .wdata_rep (wrep),
    .misalign  (misalign),
    .f3_bad    (f3_bad)
  );

`ifdef DMEM_RESPONDER_MMIO_EN
  assign is_mmio  = (cur.addr == MMIO_ADDR);
  assign mmio_err = cur.we
    ? !(cur.funct3 == F3_B || cur.funct3 == F3_W)
    : !(cur.funct3 == F3_W || cur.funct3 == F3_BU);
  assign mmio_rd  = {28'b0, led, red, green, blue};
`else
  assign is_mmio  = 1'b0;
  assign mmio_err = 1'b0;
  assign mmio_rd  = '0;
`endif

  assign fault = is_mmio ? mmio_err
                         : (misalign | f3_bad | oor);

  assign enter_resp =
    (state == ST_IDLE && req_valid && WC == 4'd0)
    || (state == ST_WAIT && cnt == 4'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      q         <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            q     <= cur;
            cnt   <= WC;
            state <= (WC == 4'd0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_err   <= fault;
        rsp_rdata <= (fault || cur.we) ? '0
                   : (is_mmio ? mmio_rd : lane_rd);
      end
    end
  end

  // Array has no reset; a store lands only as RESP is entered.
  always_ff @(posedge clk) begin
    if (enter_resp && cur.we && !fault && !is_mmio) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wrep[8*b +: 8];
      end
    end
  end

`ifdef DMEM_RESPONDER_MMIO_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {led, red, green, blue} <= 4'b0;
    end else if (enter_resp && is_mmio
                 && cur.we && !fault) begin
      {led, red, green, blue} <= cur.wdata[3:0];
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed vector bench for dmem_responder.
// Table of transactions plus stall and mid-request reset.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
`ifdef DMEM_RESPONDER_MMIO_EN
  logic led, red, green, blue;
`endif

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
`ifdef DMEM_RESPONDER_MMIO_EN
    ,
    .led        (led),
    .red        (red),
    .green      (green),
    .blue       (blue)
`endif
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    string       nm;
  } vec_t;

  vec_t v[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h want %08h",
                  nm, act, exp);
  endtask

  task automatic add(input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input logic er,
                     input string nm);
    vec_t e;
    e.we = we; e.f3 = f3; e.addr = a; e.wdata = wd;
    e.rdata = rd; e.err = er; e.nm = nm;
    v.push_back(e);
  endtask

  // Entered #1 after a posedge with the DUT idle.
  // lat counts edges from the accept edge (edge 1).
  task automatic xact(input logic we, input logic [2:0] f3,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      output logic [31:0] rd,
                      output logic er, output int lat);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = a; req_wdata = wd; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    add(1, F3_W,  32'h1000, 32'hDEADBEEF, 32'h0, 0, "sw_1000");
    add(0, F3_W,  32'h1000, 32'h0, 32'hDEADBEEF, 0, "lw_1000");
    add(1, F3_B,  32'h1003, 32'h80, 32'h0, 0, "sb_1003");
    add(0, F3_B,  32'h1003, 32'h0, 32'hFFFFFF80, 0, "lb_1003");
    add(0, F3_BU, 32'h1003, 32'h0, 32'h00000080, 0, "lbu_1003");
    add(0, F3_W,  32'h1000, 32'h0, 32'h80ADBEEF, 0, "lw_merge");
    add(0, F3_H,  32'h1001, 32'h0, 32'h0, 1, "lh_misal");
    add(1, F3_W,  32'h1002, 32'h12345678, 32'h0, 1, "sw_misal");
    add(0, F3_W,  32'h1000, 32'h0, 32'h80ADBEEF, 0, "lw_unch");
    add(0, F3_W,  32'h0FFC, 32'h0, 32'h0, 1, "lw_below");
    add(0, F3_W,  32'h2000, 32'h0, 32'h0, 1, "lw_above");
    add(1, F3_W,  32'h1004, 32'h11223344, 32'h0, 0, "sw_1004");
    add(1, F3_H,  32'h1006, 32'hFFFFA5B6, 32'h0, 0, "sh_1006");
    add(0, F3_H,  32'h1006, 32'h0, 32'hFFFFA5B6, 0, "lh_1006");
    add(0, F3_HU, 32'h1006, 32'h0, 32'h0000A5B6, 0, "lhu_1006");
    add(0, F3_B,  32'h1005, 32'h0, 32'h00000033, 0, "lb_1005");
    add(0, F3_W,  32'h1004, 32'h0, 32'hA5B63344, 0, "lw_1004");
    add(0, 3'b011, 32'h1000, 32'h0, 32'h0, 1, "ld_bad");
    add(0, 3'b110, 32'h1000, 32'h0, 32'h0, 1, "l110_bad");
    add(1, 3'b011, 32'h1000, 32'h0, 32'h0, 1, "s011_bad");
    add(0, F3_W,  32'h1000, 32'h0, 32'h80ADBEEF, 0, "lw_nowr");
    add(1, F3_W,  32'h1FFC, 32'hCAFEF00D, 32'h0, 0, "sw_last");
    add(0, F3_W,  32'h1FFC, 32'h0, 32'hCAFEF00D, 0, "lw_last");
    add(0, F3_HU, 32'h1FFE, 32'h0, 32'h0000CAFE, 0, "lhu_last");
`ifdef DMEM_RESPONDER_MMIO_EN
    add(1, F3_W,  MMIO_ADDR, 32'h0000000A, 32'h0, 0, "mmio_sw");
    add(0, F3_W,  MMIO_ADDR, 32'h0, 32'h0000000A, 0, "mmio_lw");
    add(0, F3_H,  MMIO_ADDR, 32'h0, 32'h0, 1, "mmio_lh");
`else
    add(0, F3_W,  MMIO_ADDR, 32'h0, 32'h0, 1, "mmio_oor");
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err",   32'(rsp_err), 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_ready", 32'(req_ready), 32'h1);

    foreach (v[i]) begin
      xact(v[i].we, v[i].f3, v[i].addr, v[i].wdata,
           rd, er, lat);
      chk({v[i].nm, "_rdata"}, rd, v[i].rdata);
      chk({v[i].nm, "_err"}, 32'(er), 32'(v[i].err));
      chk({v[i].nm, "_lat"}, 32'(lat), 32'd3);
    end

    // Stalled response: held stable, new request ignored.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W;
    req_addr = 32'h1000; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_we = 1'b1; req_wdata = 32'h0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("stall_lat", 32'(lat), 32'd3);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(rsp_valid), 32'h1);
      chk("stall_rdata", rsp_rdata, 32'h80ADBEEF);
      chk("stall_err",   32'(rsp_err), 32'h0);
      chk("stall_ready", 32'(req_ready), 32'h0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_done_valid", 32'(rsp_valid), 32'h0);
    chk("stall_done_ready", 32'(req_ready), 32'h1);
    xact(0, F3_W, 32'h1000, 32'h0, rd, er, lat);
    chk("stall_ignored_wr", rd, 32'h80ADBEEF);

    // Reset while a store waits: store must be dropped.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W;
    req_addr = 32'h1004; req_wdata = 32'h1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("midrst_busy", 32'(req_ready), 32'h0);
    #2 reset = 1'b0;
    #1;
    chk("midrst_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_ready", 32'(req_ready), 32'h1);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    chk("postrst_ready", 32'(req_ready), 32'h1);
    chk("postrst_valid", 32'(rsp_valid), 32'h0);
    xact(0, F3_W, 32'h1004, 32'h0, rd, er, lat);
    chk("postrst_old", rd, 32'hA5B63344);
    chk("postrst_err", 32'(er), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
